tdc_hit_gen: RTL and testbench
==============================

Name: tdc_hit_gen

Overview:
- Digital-to-time stimulus generator: the inverse of the TDC measurement path.
- Takes a requested interval as a coarse cycle count plus two 3-bit fine codes.
- Emits a start pulse and a stop pulse on a single `hit` line, spaced by the coarse count.
- Drives an 8-bit thermometer tap select for an external delay line, so each edge is offset by the fine code.
- Sits in front of the TDC `hit` input for self-test and calibration; its outputs are directly comparable to the TDC's `bin_out_start`, `bin_out_stop` and `out_count`.

Parameters:
- COARSE_W, 4: width of the coarse interval field; matches the TDC counter width.
- PULSE_W, 2: cycles `hit` stays high per pulse; legal range 1 to 15.
- GAP_CYC, 4: low cycles after the stop pulse before the next request is accepted; legal range 1 to 15.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  a request is present.
- req_ready  out  1  block can accept a request.
- req_coarse  in  COARSE_W  extra cycles between the end of the start pulse and the stop rise.
- req_fine_start  in  3  fine code for the start edge.
- req_fine_stop  in  3  fine code for the stop edge.
- hit  out  1  generated start/stop pulse line, registered.
- tap_sel  out  8  thermometer tap select for the external delay line, registered.
- busy  out  1  high from request accept until done.
- done  out  1  one-cycle pulse when the sequence completes.

Behaviour:
- Reset: rst_n=0 sampled at a rising edge forces the following on that edge, from any state including mid-pulse:
  - state=IDLE, hit=0, tap_sel=8'h00, busy=0, done=0, req_ready=0.
  - All captured request fields clear to 0.
- req_ready: equals (state==IDLE) and rst_n was high in the previous cycle.
- Handshake: accept when req_valid && req_ready. All three request fields are captured on that edge; later changes to the inputs have no effect. Without an accept, req_valid is ignored.
- States: IDLE, ARM_START, START, WAIT, ARM_STOP, STOP, GAP.
  - IDLE -> ARM_START on accept.
  - ARM_START (1 cycle): tap_sel=thermo(fine_start), hit=0.
  - START (PULSE_W cycles): hit=1, tap_sel held.
  - WAIT (coarse+1 cycles): hit=0. The minimum of 1 low cycle guarantees a distinct stop edge even when coarse=0.
  - ARM_STOP (1 cycle): tap_sel=thermo(fine_stop), hit=0.
  - STOP (PULSE_W cycles): hit=1.
  - GAP (GAP_CYC cycles): hit=0, tap_sel=8'h00.
  - GAP -> IDLE; done=1 for exactly the IDLE-entry cycle.
- tap_sel only changes while hit=0, so it is stable one full cycle before every rising edge of hit.
- Timing, with the accept edge as cycle N:
  - hit rises (registered) at N+2.
  - stop rise at N+2+PULSE_W+(coarse+1)+1.
  - start-rise to stop-rise distance = PULSE_W+coarse+2 cycles.
- busy: 1 from N+1 until the cycle done is asserted, inclusive of the done cycle being 0 (busy falls when done rises).
- Thermometer rule: thermo(k) sets the k least-significant bits.
  - k=0 gives 8'h00; k=5 gives 8'h1F; k=7 gives 8'h7F.
  - Bit 7 is never set.
- Coarse counter: a down-counter loaded with coarse on WAIT entry; WAIT exits when it reaches 0. Full scale coarse=2^COARSE_W-1 gives WAIT=2^COARSE_W cycles, with no wrap.
- Pulse and gap counters: 4-bit, loaded on state entry; no wrap within the legal parameter range.
- A request arriving at the same cycle done asserts is accepted, because req_ready=1 in IDLE; there are no back-to-back bubbles beyond GAP_CYC.

Optional Feature:
- Macro: TDC_HIT_GEN_BURST_EN.
- Defined:
  - Adds input port req_burst [3:0], captured at accept.
  - After GAP the block returns to ARM_START with the same fields, until burst+1 start/stop pairs have been issued; only then does it enter IDLE and pulse done.
  - busy stays high through the entire burst.
  - Reset aborts the burst immediately.
- Not defined: the port is absent and behaviour is exactly one pair per request.

Decomposition:
- Package tdc_gen_pkg holds:
  - State enum.
  - FINE_W=3, THERMO_W=8.
  - Counter width CNT_W=4.
- One sub-module: bin_to_thermo3, a pure combinational 3-to-8 thermometer decoder. It is instantiated once; a mux selects fine_start or fine_stop ahead of it, and the output register is in the parent.

Test Plan:
1. Reset mid-pulse: assert rst_n=0 during START -> next edge hit=0, tap_sel=00, busy=0, state IDLE; req_ready=1 one cycle after rst_n returns high.
2. Nominal: coarse=3, fine_start=2, fine_stop=5, PULSE_W=2 -> check all of:
   - hit rises at N+2 with tap_sel=03.
   - stop rise at N+9 with tap_sel=1F.
   - done pulse at N+2+2+4+1+2+4=N+15.
3. Boundary coarse=0 and coarse=15 -> start-rise to stop-rise = 4 and 19 cycles respectively; hit has at least one low cycle between the pulses.
4. Fine extremes: fine_start=0, fine_stop=7 -> tap_sel=00 at the start rise and 7F at the stop rise; tap_sel never changes while hit=1.
5. Back-to-back: req_valid held high with new fields changing every cycle -> second accept on the done cycle; each sequence uses only its fields captured at accept.
6. With TDC_HIT_GEN_BURST_EN, burst=2 -> exactly 3 start/stop pairs each separated by GAP_CYC low cycles; a single done; busy continuous.

Source files
------------

// File: rtl/tdc_gen_pkg.sv
// Shared types and widths for the TDC hit generator.
// Optional burst mode is enabled with TDC_HIT_GEN_BURST_EN.
package tdc_gen_pkg;

  localparam int FINE_W   = 3;
  localparam int THERMO_W = 8;
  localparam int CNT_W    = 4;

  typedef enum logic [2:0] {
    IDLE,
    ARM_START,
    START,
    WAIT,
    ARM_STOP,
    STOP,
    GAP
  } state_e;

endpackage

// File: rtl/bin_to_thermo3.sv
// 3-bit binary to 8-bit thermometer decoder, purely combinational.
// Code k sets the k least-significant taps; bit 7 is never set.
module bin_to_thermo3
  import tdc_gen_pkg::*;
(
  input  logic [FINE_W-1:0]   bin_i,
  output logic [THERMO_W-1:0] thermo_o
);

  always_comb begin
    thermo_o = '0;
    for (int i = 0; i < THERMO_W; i++) begin
      thermo_o[i] = (i < int'(bin_i));
    end
  end

endmodule

// File: rtl/tdc_hit_gen.sv
// Start/stop hit pulse generator with fine tap select for a delay line.
// Define TDC_HIT_GEN_BURST_EN to add req_burst (repeat pairs per request).
module tdc_hit_gen
  import tdc_gen_pkg::*;
#(
  parameter int COARSE_W = 4,
  parameter int PULSE_W  = 2,
  parameter int GAP_CYC  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [COARSE_W-1:0] req_coarse,
  input  logic [FINE_W-1:0]   req_fine_start,
  input  logic [FINE_W-1:0]   req_fine_stop,
`ifdef TDC_HIT_GEN_BURST_EN
  input  logic [3:0]          req_burst,
`endif
  output logic                hit,
  output logic [THERMO_W-1:0] tap_sel,
  output logic                busy,
  output logic                done
);

  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC - 1);

  state_e                state_q;
  logic                  rstn_q;
  logic [COARSE_W-1:0]   coarse_q;
  logic [COARSE_W-1:0]   crs_q;
  logic [CNT_W-1:0]      cnt_q;
  logic [FINE_W-1:0]     fs_q;
  logic [FINE_W-1:0]     fe_q;
  logic [3:0]            burst_q;
  logic                  hit_q;
  logic                  busy_q;
  logic                  done_q;
  logic [THERMO_W-1:0]   tap_q;
  logic [FINE_W-1:0]     fine_d;
  logic [THERMO_W-1:0]   thermo_d;
  logic [3:0]            burst_d;
  logic                  accept;

`ifdef TDC_HIT_GEN_BURST_EN
  assign burst_d = req_burst;
`else
  assign burst_d = 4'd0;
`endif

  assign req_ready = (state_q == IDLE) && rstn_q;
  assign accept    = req_valid && req_ready;
  assign fine_d    = (state_q == ARM_STOP) ? fe_q : fs_q;

  bin_to_thermo3 u_thermo (
    .bin_i    (fine_d),
    .thermo_o (thermo_d)
  );

  // Outputs are registered from the current state, so they trail it by a cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rstn_q   <= 1'b0;
      coarse_q <= '0;
      crs_q    <= '0;
      cnt_q    <= '0;
      fs_q     <= '0;
      fe_q     <= '0;
      burst_q  <= '0;
      hit_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      tap_q    <= '0;
    end else begin
      rstn_q <= 1'b1;
      hit_q  <= (state_q == START) || (state_q == STOP);
      busy_q <= (state_q != IDLE);
      done_q <= (state_q == IDLE) && busy_q;
      unique case (state_q)
        IDLE: begin
          tap_q <= '0;
          if (accept) begin
            coarse_q <= req_coarse;
            fs_q     <= req_fine_start;
            fe_q     <= req_fine_stop;
            burst_q  <= burst_d;
            state_q  <= ARM_START;
          end
        end
        ARM_START: begin
          tap_q   <= thermo_d;
          cnt_q   <= PULSE_LD;
          state_q <= START;
        end
        START: begin
          if (cnt_q == '0) begin
            crs_q   <= coarse_q;
            state_q <= WAIT;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        WAIT: begin
          if (crs_q == '0) state_q <= ARM_STOP;
          else crs_q <= crs_q - 1'b1;
        end
        ARM_STOP: begin
          tap_q   <= thermo_d;
          cnt_q   <= PULSE_LD;
          state_q <= STOP;
        end
        STOP: begin
          if (cnt_q == '0) begin
            cnt_q   <= GAP_LD;
            state_q <= GAP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        GAP: begin
          tap_q <= '0;
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (burst_q != '0) begin
            burst_q <= burst_q - 1'b1;
            state_q <= ARM_START;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hit     = hit_q;
  assign tap_sel = tap_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_tdc_hit_gen.sv
// Directed bench for tdc_hit_gen with hand-computed cycle offsets.
// Burst checks are built when TDC_HIT_GEN_BURST_EN is defined.
module tb_tdc_hit_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [3:0] req_coarse = '0;
  logic [2:0] req_fine_start = '0;
  logic [2:0] req_fine_stop = '0;
`ifdef TDC_HIT_GEN_BURST_EN
  logic [3:0] req_burst = '0;
`endif
  logic       hit;
  logic [7:0] tap_sel;
  logic       busy;
  logic       done;

  int n_chk = 0;
  int n_fail = 0;

  logic       h[64];
  logic [7:0] t[64];
  logic       d[64];
  logic       b[64];

  tdc_hit_gen #(
    .COARSE_W (4),
    .PULSE_W  (2),
    .GAP_CYC  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_coarse     (req_coarse),
    .req_fine_start (req_fine_start),
    .req_fine_stop  (req_fine_stop),
`ifdef TDC_HIT_GEN_BURST_EN
    .req_burst      (req_burst),
`endif
    .hit            (hit),
    .tap_sel        (tap_sel),
    .busy           (busy),
    .done           (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rise(input int n, input int len);
    int c = 0;
    for (int k = 1; k < len; k++) begin
      if (h[k] && !h[k-1]) begin
        if (c == n) return k;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int nrise(input int len);
    int c = 0;
    for (int k = 1; k < len; k++) if (h[k] && !h[k-1]) c++;
    return c;
  endfunction

  function automatic int done_at(input int n, input int len);
    int c = 0;
    for (int k = 0; k < len; k++) begin
      if (d[k]) begin
        if (c == n) return k;
        c++;
      end
    end
    return -1;
  endfunction

  function automatic int ndone(input int len);
    int c = 0;
    for (int k = 0; k < len; k++) if (d[k]) c++;
    return c;
  endfunction

  function automatic int bad_tap(input int len);
    int c = 0;
    for (int k = 1; k < len; k++) if (t[k] != t[k-1] && h[k]) c++;
    return c;
  endfunction

  function automatic int busy_holes(input int last);
    int c = 0;
    for (int k = 1; k < last; k++) if (!b[k]) c++;
    return c;
  endfunction

  // Sample index k holds outputs just after the accept edge plus k edges.
  task automatic run(input int len, input bit b2b);
    tick();
    if (!b2b) req_valid = 1'b0;
    for (int k = 0; k < len; k++) begin
      h[k] = hit;
      t[k] = tap_sel;
      d[k] = done;
      b[k] = busy;
      if (b2b) begin
        req_coarse     = 4'((k + 1) % 5);
        req_fine_start = 3'((k + 1) % 8);
        req_fine_stop  = 3'(7 - ((k + 1) % 8));
        req_valid      = (k + 1 <= 12);
      end
      tick();
    end
    req_valid = 1'b0;
  endtask

  task automatic go(input int c, input int fs, input int fe,
                    input int burst, input int len, input bit b2b);
    int w = 0;
    while (!req_ready && w < 60) begin
      tick();
      w++;
    end
    chk("ready_wait", req_ready, 1);
    req_coarse     = 4'(c);
    req_fine_start = 3'(fs);
    req_fine_stop  = 3'(fe);
`ifdef TDC_HIT_GEN_BURST_EN
    req_burst      = 4'(burst);
`else
    if (burst != 0) $display("note: burst ignored");
`endif
    req_valid = 1'b1;
    run(len, b2b);
  endtask

  initial begin
    tick();
    tick();
    chk("rst_hit", hit, 0);
    chk("rst_tap", tap_sel, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", req_ready, 0);
    rst_n = 1'b1;
    chk("rel_ready0", req_ready, 0);
    tick();
    chk("rel_ready1", req_ready, 1);

    req_coarse = 4'd3;
    req_fine_start = 3'd2;
    req_fine_stop = 3'd5;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    chk("mid_hit_pre", hit, 1);
    chk("mid_tap_pre", tap_sel, 8'h03);
    rst_n = 1'b0;
    tick();
    chk("mid_hit", hit, 0);
    chk("mid_tap", tap_sel, 8'h00);
    chk("mid_busy", busy, 0);
    chk("mid_ready", req_ready, 0);
    chk("mid_done", done, 0);
    rst_n = 1'b1;
    tick();
    chk("mid_ready1", req_ready, 1);
    tick();
    chk("mid_idle_hit", hit, 0);

    go(3, 2, 5, 0, 24, 1'b0);
    chk("nom_rise0", rise(0, 24), 2);
    chk("nom_tap0", t[2], 8'h03);
    chk("nom_rise1", rise(1, 24), 9);
    chk("nom_tap1", t[9], 8'h1F);
    chk("nom_done", done_at(0, 24), 15);
    chk("nom_ndone", ndone(24), 1);
    chk("nom_busy", busy_holes(15), 0);
    chk("nom_busy0", b[0], 0);
    chk("nom_busyend", b[15], 0);
    chk("nom_badtap", bad_tap(24), 0);
    chk("nom_gaptap", t[12], 8'h00);

    go(0, 3, 4, 0, 20, 1'b0);
    chk("c0_dist", rise(1, 20) - rise(0, 20), 4);
    chk("c0_low", rise(1, 20) - rise(0, 20) - 2, 2);
    chk("c0_lowhit", h[4], 0);

    go(15, 1, 1, 0, 40, 1'b0);
    chk("c15_dist", rise(1, 40) - rise(0, 40), 19);
    chk("c15_done", done_at(0, 40), 27);

    go(5, 0, 7, 0, 24, 1'b0);
    chk("fx_tap0", t[rise(0, 24)], 8'h00);
    chk("fx_tap1", t[rise(1, 24)], 8'h7F);
    chk("fx_badtap", bad_tap(24), 0);

    go(0, 0, 7, 0, 32, 1'b1);
    chk("b2b_nrise", nrise(32), 4);
    chk("b2b_r0", rise(0, 32), 2);
    chk("b2b_r1", rise(1, 32), 6);
    chk("b2b_r2", rise(2, 32), 14);
    chk("b2b_r3", rise(3, 32), 20);
    chk("b2b_t0", t[2], 8'h00);
    chk("b2b_t1", t[6], 8'h7F);
    chk("b2b_t2", t[14], 8'h0F);
    chk("b2b_t3", t[20], 8'h07);
    chk("b2b_d0", done_at(0, 32), 12);
    chk("b2b_d1", done_at(1, 32), 26);
    chk("b2b_badtap", bad_tap(32), 0);

`ifdef TDC_HIT_GEN_BURST_EN
    go(0, 1, 2, 2, 44, 1'b0);
    chk("bst_nrise", nrise(44), 6);
    chk("bst_r2", rise(2, 44), 13);
    chk("bst_r4", rise(4, 44), 24);
    chk("bst_r5", rise(5, 44), 28);
    chk("bst_ndone", ndone(44), 1);
    chk("bst_done", done_at(0, 44), 34);
    chk("bst_busy", busy_holes(34), 0);
    chk("bst_low", h[12], 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
